// File: rtl/fifo_index_ctrl.sv
// fifo_index_ctrl -- occupancy and index controller for a circular FIFO.
//
// Accepts per-cycle requests to push and/or pop a number of entries. A
// request is granted in full or not at all. Grants, occupancy and indices
// are registered, so they are visible right after the edge that sampled
// the request.
//
// Parameters:
//   depth                 FIFO capacity in entries (>= 1)
//   push_width            width of push_req / push
//   pop_width             width of pop_req / pop
//   simultaneous_push_pop 1: push and pop may be granted in the same cycle
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   push_req   entries requested for push this cycle
//   pop_req    entries requested for pop this cycle
//   push       granted push count (registered)
//   pop        granted pop count (registered)
//   cnt        current occupancy
//   wr_ptr     write index (0 .. depth-1)
//   rd_ptr     read index  (0 .. depth-1)
//   full       cnt == depth
//   empty      cnt == 0
//   err_reject rejection indicator
//
// Build option:
//   FIFO_INDEX_CTRL_STICKY_ERR_EN  when defined, err_reject latches on the
//   first rejection and stays set until reset; otherwise it is a one-cycle
//   pulse following each rejected request.

module fifo_index_ctrl #(
  parameter int depth                 = 1,
  parameter int push_width            = 1,
  parameter int pop_width             = 1,
  parameter int simultaneous_push_pop = 1,
  localparam int cnt_w = ($clog2(depth + 1) < 1) ? 1 : $clog2(depth + 1),
  localparam int ptr_w = ($clog2(depth) < 1) ? 1 : $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [push_width-1:0] push_req,
  input  logic [pop_width-1:0]  pop_req,
  output logic [push_width-1:0] push,
  output logic [pop_width-1:0]  pop,
  output logic [cnt_w-1:0]      cnt,
  output logic [ptr_w-1:0]      wr_ptr,
  output logic [ptr_w-1:0]      rd_ptr,
  output logic                  full,
  output logic                  empty,
  output logic                  err_reject
);

  // Two guard bits above the widest operand keep cnt+push_req-pop_req
  // from wrapping in any intermediate step.
  localparam int max_w = (cnt_w > push_width)
                         ? ((cnt_w > pop_width) ? cnt_w : pop_width)
                         : ((push_width > pop_width) ? push_width : pop_width);
  localparam int aw = max_w + 2;
  localparam int sw = aw + 1;
  localparam logic [aw-1:0] depth_a = aw'(depth);

  logic [push_width-1:0] push_q, push_d;
  logic [pop_width-1:0]  pop_q, pop_d;
  logic [cnt_w-1:0]      cnt_q, cnt_d;
  logic [ptr_w-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ptr_w-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  err_q, err_d;

  logic [aw-1:0] push_ext;
  logic [aw-1:0] pop_ext;
  logic [aw-1:0] total;
  logic          any_req;
  logic          both_req;
  logic          fits;
  logic          grant;
  logic          reject;

  // Modular advance with a single conditional subtraction; valid because a
  // granted count never exceeds depth for the configurations in use.
  function automatic logic [ptr_w-1:0] advance(input logic [ptr_w-1:0] ptr,
                                               input logic [aw-1:0]    n);
    logic [sw-1:0] sum;
    sum = sw'(ptr) + sw'(n);
    if (sum >= sw'(depth)) begin
      sum = sum - sw'(depth);
    end
    return ptr_w'(sum);
  endfunction

  always_comb begin
    push_ext = aw'(push_req);
    pop_ext  = aw'(pop_req);
    total    = aw'(cnt_q) + push_ext;
    any_req  = (push_req != '0) || (pop_req != '0);
    both_req = (push_req != '0) && (pop_req != '0);
    // Resulting occupancy must lie within 0..depth; push-only and pop-only
    // are the same test with the other operand at zero.
    fits     = (pop_ext <= total) && ((total - pop_ext) <= depth_a);
    grant    = any_req && fits && !(both_req && (simultaneous_push_pop == 0));
    reject   = any_req && !grant;

    push_d   = '0;
    pop_d    = '0;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (grant) begin
      push_d   = push_req;
      pop_d    = pop_req;
      cnt_d    = cnt_w'(total - pop_ext);
      wr_ptr_d = advance(wr_ptr_q, push_ext);
      rd_ptr_d = advance(rd_ptr_q, pop_ext);
    end

`ifdef FIFO_INDEX_CTRL_STICKY_ERR_EN
    err_d = err_q | reject;
`else
    err_d = reject;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push_q   <= '0;
      pop_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      push_q   <= push_d;
      pop_q    <= pop_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  // Status flags decode the registered count directly, so they follow reset
  // asynchronously along with it.
  assign push       = push_q;
  assign pop        = pop_q;
  assign cnt        = cnt_q;
  assign wr_ptr     = wr_ptr_q;
  assign rd_ptr     = rd_ptr_q;
  assign full       = (cnt_q == cnt_w'(depth));
  assign empty      = (cnt_q == '0);
  assign err_reject = err_q;

endmodule

// File: tb/tb_fifo_index_ctrl.sv
// tb_fifo_index_ctrl -- self-checking bench for fifo_index_ctrl.
//
// Two instances (depth=4, 2-bit request ports) share clock, reset and
// requests: "s" allows simultaneous push/pop, "n" does not. A behavioural
// model tracks occupancy and indices as plain integers for each instance.

module tb_fifo_index_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] push_req = '0;
  logic [1:0] pop_req = '0;

  logic [1:0] push_s, pop_s, wr_s, rd_s;
  logic [2:0] cnt_s;
  logic       full_s, empty_s, err_s;
  logic [1:0] push_n, pop_n, wr_n, rd_n;
  logic [2:0] cnt_n;
  logic       full_n, empty_n, err_n;

  int checks = 0;
  int errors = 0;

  int m_cnt[2];
  int m_wr[2];
  int m_rd[2];
  int m_push[2];
  int m_pop[2];
  int m_err[2];

  fifo_index_ctrl #(.depth(DEPTH), .push_width(2), .pop_width(2),
                    .simultaneous_push_pop(1)) dut_s (
    .clk(clk), .reset_n(reset_n), .push_req(push_req), .pop_req(pop_req),
    .push(push_s), .pop(pop_s), .cnt(cnt_s), .wr_ptr(wr_s), .rd_ptr(rd_s),
    .full(full_s), .empty(empty_s), .err_reject(err_s)
  );

  fifo_index_ctrl #(.depth(DEPTH), .push_width(2), .pop_width(2),
                    .simultaneous_push_pop(0)) dut_n (
    .clk(clk), .reset_n(reset_n), .push_req(push_req), .pop_req(pop_req),
    .push(push_n), .pop(pop_n), .cnt(cnt_n), .wr_ptr(wr_n), .rd_ptr(rd_n),
    .full(full_n), .empty(empty_n), .err_reject(err_n)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i]  = 0;
      m_wr[i]   = 0;
      m_rd[i]   = 0;
      m_push[i] = 0;
      m_pop[i]  = 0;
      m_err[i]  = 0;
    end
  endtask

  task automatic modelStep(input int p, input int q);
    for (int i = 0; i < 2; i++) begin
      int nxt;
      bit rej;
      bit sim;
      sim       = (i == 0);
      rej       = 1'b0;
      m_push[i] = 0;
      m_pop[i]  = 0;
      if (p == 0 && q == 0) begin
        rej = 1'b0;
      end else if (p != 0 && q != 0 && !sim) begin
        rej = 1'b1;
      end else begin
        nxt = m_cnt[i] + p - q;
        if (nxt < 0 || nxt > DEPTH) begin
          rej = 1'b1;
        end else begin
          m_push[i] = p;
          m_pop[i]  = q;
          m_cnt[i]  = nxt;
          m_wr[i]   = (m_wr[i] + p) % DEPTH;
          m_rd[i]   = (m_rd[i] + q) % DEPTH;
        end
      end
`ifdef FIFO_INDEX_CTRL_STICKY_ERR_EN
      m_err[i] = (m_err[i] != 0 || rej) ? 1 : 0;
`else
      m_err[i] = rej ? 1 : 0;
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, ".s.push"},  32'(push_s),  32'(m_push[0]));
    chk({tag, ".s.pop"},   32'(pop_s),   32'(m_pop[0]));
    chk({tag, ".s.cnt"},   32'(cnt_s),   32'(m_cnt[0]));
    chk({tag, ".s.wr"},    32'(wr_s),    32'(m_wr[0]));
    chk({tag, ".s.rd"},    32'(rd_s),    32'(m_rd[0]));
    chk({tag, ".s.full"},  32'(full_s),  32'(m_cnt[0] == DEPTH));
    chk({tag, ".s.empty"}, 32'(empty_s), 32'(m_cnt[0] == 0));
    chk({tag, ".s.err"},   32'(err_s),   32'(m_err[0]));
    chk({tag, ".n.push"},  32'(push_n),  32'(m_push[1]));
    chk({tag, ".n.pop"},   32'(pop_n),   32'(m_pop[1]));
    chk({tag, ".n.cnt"},   32'(cnt_n),   32'(m_cnt[1]));
    chk({tag, ".n.wr"},    32'(wr_n),    32'(m_wr[1]));
    chk({tag, ".n.rd"},    32'(rd_n),    32'(m_rd[1]));
    chk({tag, ".n.full"},  32'(full_n),  32'(m_cnt[1] == DEPTH));
    chk({tag, ".n.empty"}, 32'(empty_n), 32'(m_cnt[1] == 0));
    chk({tag, ".n.err"},   32'(err_n),   32'(m_err[1]));
  endtask

  // Drives one request pair, lets one rising edge sample it, then checks.
  task automatic applyStimulus(input int p, input int q, input string tag);
    push_req = 2'(p);
    pop_req  = 2'(q);
    modelStep(p, q);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Asserts reset away from any edge, checks the immediate effect, keeps
  // it asserted across an edge with live requests, then releases it.
  task automatic resetSequence(input string tag);
    reset_n  = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, ".async"});
    push_req = 2'($urandom_range(3, 1));
    pop_req  = 2'($urandom_range(3, 1));
    @(posedge clk);
    #1;
    checkOutput({tag, ".held"});
    push_req = '0;
    pop_req  = '0;
    reset_n  = 1'b1;
  endtask

  initial begin
    int p;
    int q;
    modelReset();

    #2;
    checkOutput("por");
    push_req = 2'd3;
    @(posedge clk);
    #1;
    checkOutput("por_edge");
    push_req = '0;
    reset_n  = 1'b1;

    applyStimulus(3, 0, "push3");
    applyStimulus(2, 0, "push_over");
    applyStimulus(0, 0, "idle");
    applyStimulus(1, 2, "push1_pop2");

    @(negedge clk);
    resetSequence("rst1");
    applyStimulus(3, 0, "w_push3");
    applyStimulus(0, 2, "w_pop2");
    applyStimulus(2, 0, "w_push2_wrap");
    applyStimulus(0, 3, "w_pop3_wrap");
    applyStimulus(0, 1, "pop_empty");
    applyStimulus(2, 0, "push2");
    applyStimulus(3, 0, "push_over2");
    applyStimulus(2, 0, "fill");
    applyStimulus(1, 0, "push_full");
    applyStimulus(2, 2, "full_swap");

    #3;
    resetSequence("rst_mid");

    for (int i = 0; i < 400; i++) begin
      p = $urandom_range(3);
      q = $urandom_range(3);
      if ($urandom_range(3) == 0) begin
        q = 0;
      end
      if ($urandom_range(3) == 0) begin
        p = 0;
      end
      applyStimulus(p, q, $sformatf("rnd%0d", i));
      if ($urandom_range(63) == 0) begin
        #2;
        resetSequence($sformatf("rnd_rst%0d", i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
